// File: rtl/conv_window_scheduler.sv
// Purpose : walks every output window (channel, row, column) of one convolution
//           pass and hands each one to a free multiplier picked round-robin.
// Latency : 2 edges from an accepted start to the first disp_valid, then up to 1 dispatch/cycle.
// Backpr. : no dispatch while every multiplier is busy; RUN holds until a mult_done frees one.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   start              begin a pass (sampled only in IDLE)
//   mult_done[NMULT]   one-cycle completion pulse per multiplier
//   disp_valid         one-cycle dispatch strobe; disp_* held between strobes
//   disp_mult          target multiplier index
//   disp_k/row/col     channel and top-left corner of the dispatched window
//   disp_idx           sequential window number, 0..TOTAL-1
//   mult_busy          registered busy bitmap
//   busy / done / err  pass in progress / one-cycle completion pulse / sticky protocol error
module conv_window_scheduler #(
  parameter int N     = 32,
  parameter int F     = 3,
  parameter int K     = 3,
  parameter int S     = 1,
  parameter int NMULT = 64,
  parameter int MIDX  = 6,
  parameter int CW    = 24
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [NMULT-1:0] mult_done,
  output logic             disp_valid,
  output logic [MIDX-1:0]  disp_mult,
  output logic [CW-1:0]    disp_k,
  output logic [CW-1:0]    disp_row,
  output logic [CW-1:0]    disp_col,
  output logic [CW-1:0]    disp_idx,
  output logic [NMULT-1:0] mult_busy,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int            OUT      = (N - F) / S + 1;
  localparam logic [CW-1:0] TOTAL    = CW'(OUT * OUT * K);
  // Largest legal top-left coordinate; a step past it wraps the counter.
  localparam logic [CW-1:0] LAST_POS = CW'(N - F);
  localparam logic [CW-1:0] STEP     = CW'(S);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_FIN} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    iss_cnt, cmp_cnt, cmp_inc, cmp_nxt;
  logic [CW-1:0]    k_cnt, row_cnt, col_cnt;
  logic [MIDX-1:0]  rr_ptr, rr_nxt;
  logic             gnt;
  logic [MIDX-1:0]  gnt_idx;
  logic [NMULT-1:0] gnt_vec, fin_vec, free_sh;
  logic             spur;
  logic             col_wrap, row_wrap;
  int               cand;

  // Round-robin search over the registered bitmap, starting at rr_ptr.
  // A multiplier freed this cycle is not seen until the bitmap updates.
  always_comb begin
    gnt     = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    free_sh = '0;
    for (int off = 0; off < NMULT; off++) begin
      cand    = (int'(rr_ptr) + off) % NMULT;
      free_sh = ~mult_busy >> cand;
      if (!gnt && state == ST_RUN && free_sh[0]) begin
        gnt     = 1'b1;
        gnt_idx = MIDX'(cand);
      end
    end
  end

  assign gnt_vec = gnt ? (NMULT'(1) << gnt_idx) : '0;
  assign rr_nxt  = (int'(gnt_idx) == NMULT - 1) ? '0 : gnt_idx + 1'b1;

  // Only completions from busy multipliers count; the rest flag an error.
  assign fin_vec = mult_done & mult_busy;
  assign spur    = |(mult_done & ~mult_busy);

  always_comb begin
    cmp_inc = '0;
    for (int i = 0; i < NMULT; i++) begin
      cmp_inc = cmp_inc + {{(CW-1){1'b0}}, fin_vec[i]};
    end
  end

  assign cmp_nxt  = cmp_cnt + cmp_inc;
  assign col_wrap = (col_cnt + STEP) > LAST_POS;
  assign row_wrap = (row_cnt + STEP) > LAST_POS;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_RUN;
      ST_RUN:   if (gnt && (iss_cnt + 1'b1) == TOTAL) state_nxt = ST_DRAIN;
      // The completion arriving this cycle is included so done follows it by one cycle.
      ST_DRAIN: if (cmp_nxt == TOTAL) state_nxt = ST_FIN;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      disp_valid <= 1'b0;
      disp_mult  <= '0;
      disp_k     <= '0;
      disp_row   <= '0;
      disp_col   <= '0;
      disp_idx   <= '0;
      mult_busy  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      iss_cnt    <= '0;
      cmp_cnt    <= '0;
      k_cnt      <= '0;
      row_cnt    <= '0;
      col_cnt    <= '0;
      rr_ptr     <= '0;
    end else begin
      disp_valid <= gnt;
      busy       <= (state_nxt == ST_RUN) || (state_nxt == ST_DRAIN);
      done       <= (state_nxt == ST_FIN);
      if (state == ST_IDLE && start) begin
        mult_busy <= '0;
        err       <= 1'b0;
        iss_cnt   <= '0;
        cmp_cnt   <= '0;
        k_cnt     <= '0;
        row_cnt   <= '0;
        col_cnt   <= '0;
        rr_ptr    <= '0;
      end else begin
        // Grant and done never hit the same bit: grants need busy=0, counted dones need busy=1.
        mult_busy <= (mult_busy & ~mult_done) | gnt_vec;
        cmp_cnt   <= cmp_nxt;
        if (spur) err <= 1'b1;
        if (gnt) begin
          disp_mult <= gnt_idx;
          disp_k    <= k_cnt;
          disp_row  <= row_cnt;
          disp_col  <= col_cnt;
          disp_idx  <= iss_cnt;
          iss_cnt   <= iss_cnt + 1'b1;
          rr_ptr    <= rr_nxt;
          if (!col_wrap) begin
            col_cnt <= col_cnt + STEP;
          end else begin
            col_cnt <= '0;
            if (!row_wrap) begin
              row_cnt <= row_cnt + STEP;
            end else begin
              row_cnt <= '0;
              k_cnt   <= k_cnt + 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Purpose : drives two scheduler instances (unit stride; stride 2 with two channels)
//           through directed passes and compares every cycle with a window-level model.
// Latency : n/a (bench).  Backpressure: completions driven by an auto responder or by hand.
module tb_conv_window_scheduler;

  localparam int NM = 4;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          start_a = 1'b0, start_b = 1'b0;
  logic [NM-1:0] man_a = '0, man_b = '0;
  logic [NM-1:0] hold_a = '0, hold_b = '0, auto_val_a = '0, auto_val_b = '0;
  logic          auto_a = 1'b0, auto_b = 1'b0;
  wire  [NM-1:0] md_a = (auto_a ? auto_val_a : '0) | man_a;
  wire  [NM-1:0] md_b = (auto_b ? auto_val_b : '0) | man_b;

  logic          a_valid, b_valid, a_busy, b_busy, a_done, b_done, a_err, b_err;
  logic [1:0]    a_mult, b_mult;
  logic [CW-1:0] a_k, a_row, a_col, a_idx, b_k, b_row, b_col, b_idx;
  logic [NM-1:0] a_mbusy, b_mbusy;

  conv_window_scheduler #(.N(5), .F(3), .K(1), .S(1), .NMULT(NM), .MIDX(2), .CW(CW)) dut_a (
    .clk(clk), .rstn(rstn), .start(start_a), .mult_done(md_a),
    .disp_valid(a_valid), .disp_mult(a_mult), .disp_k(a_k), .disp_row(a_row),
    .disp_col(a_col), .disp_idx(a_idx), .mult_busy(a_mbusy), .busy(a_busy),
    .done(a_done), .err(a_err));

  conv_window_scheduler #(.N(6), .F(2), .K(2), .S(2), .NMULT(NM), .MIDX(2), .CW(CW)) dut_b (
    .clk(clk), .rstn(rstn), .start(start_b), .mult_done(md_b),
    .disp_valid(b_valid), .disp_mult(b_mult), .disp_k(b_k), .disp_row(b_row),
    .disp_col(b_col), .disp_idx(b_idx), .mult_busy(b_mbusy), .busy(b_busy),
    .done(b_done), .err(b_err));

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Auto responder: each dispatched multiplier completes in the following cycle.
  initial forever begin
    @(posedge clk);
    #1;
    auto_val_a = hold_a;
    hold_a     = a_valid ? (4'b0001 << a_mult) : 4'b0000;
    auto_val_b = hold_b;
    hold_b     = b_valid ? (4'b0001 << b_mult) : 4'b0000;
  end

  // ---------------- window-level model ----------------
  int mp_n[2] = '{5, 6};
  int mp_f[2] = '{3, 2};
  int mp_k[2] = '{1, 2};
  int mp_s[2] = '{1, 2};

  int            m_phase[2];   // 0 idle, 1 issuing, 2 waiting for completions, 3 finished
  int            m_iss[2], m_cmp[2], m_ptr[2];
  logic [NM-1:0] m_bz[2];
  logic          m_err[2];
  logic          e_vld[2];
  int            e_mult[2], e_k[2], e_row[2], e_col[2], e_idx[2];

  task automatic model_reset(input int i);
    m_phase[i] = 0; m_iss[i] = 0; m_cmp[i] = 0; m_ptr[i] = 0;
    m_bz[i] = '0; m_err[i] = 1'b0; e_vld[i] = 1'b0;
    e_mult[i] = 0; e_k[i] = 0; e_row[i] = 0; e_col[i] = 0; e_idx[i] = 0;
  endtask

  task automatic model_step(input int i, input logic st, input logic [NM-1:0] md);
    int outp, total, w, c;
    logic [NM-1:0] nb, sh;
    outp = (mp_n[i] - mp_f[i]) / mp_s[i] + 1;
    total = outp * outp * mp_k[i];
    e_vld[i] = 1'b0;
    if (m_phase[i] == 0) begin
      if (st) begin
        m_phase[i] = 1; m_iss[i] = 0; m_cmp[i] = 0; m_ptr[i] = 0;
        m_bz[i] = '0; m_err[i] = 1'b0;
      end else if ((md & ~m_bz[i]) != 0) begin
        m_err[i] = 1'b1;
      end
    end else begin
      if ((md & ~m_bz[i]) != 0) m_err[i] = 1'b1;
      m_cmp[i] = m_cmp[i] + $countones(md & m_bz[i]);
      nb = m_bz[i] & ~md;
      if (m_phase[i] == 1) begin
        w = -1;
        for (int o = 0; o < NM; o++) begin
          c = (m_ptr[i] + o) % NM;
          sh = m_bz[i] >> c;
          if (w < 0 && sh[0] == 1'b0) w = c;
        end
        if (w >= 0) begin
          nb = nb | (4'b0001 << w);
          m_ptr[i] = (w + 1) % NM;
          e_vld[i] = 1'b1;
          e_mult[i] = w;
          e_idx[i] = m_iss[i];
          e_k[i] = m_iss[i] / (outp * outp);
          e_row[i] = ((m_iss[i] / outp) % outp) * mp_s[i];
          e_col[i] = (m_iss[i] % outp) * mp_s[i];
          m_iss[i]++;
          if (m_iss[i] == total) m_phase[i] = 2;
        end
      end else if (m_phase[i] == 2) begin
        if (m_cmp[i] == total) m_phase[i] = 3;
      end else begin
        m_phase[i] = 0;
      end
      m_bz[i] = nb;
    end
  endtask

  // ---------------- recording ----------------
  int qa_mult[$], qa_row[$], qa_col[$], qa_k[$], qa_idx[$], qa_cyc[$];
  int qb_k[$], qb_row[$], qb_col[$];
  int dn_cnt[2], done_cyc[2], last_cmp[2], start_cyc[2];

  task automatic clear_rec();
    qa_mult.delete(); qa_row.delete(); qa_col.delete(); qa_k.delete();
    qa_idx.delete(); qa_cyc.delete();
    qb_k.delete(); qb_row.delete(); qb_col.delete();
    for (int i = 0; i < 2; i++) begin
      dn_cnt[i] = 0; done_cyc[i] = -1; last_cmp[i] = -1; start_cyc[i] = -1;
    end
  endtask

  // Single compare process: sample away from the active edge, check, then advance the model.
  initial begin : cmp_proc
    logic dv, dbz, ddn, der, st;
    logic [NM-1:0] dmb, md;
    int dm, dk, dr, dc, di;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        dv  = (i == 0) ? a_valid : b_valid;
        dm  = (i == 0) ? int'(a_mult) : int'(b_mult);
        dk  = (i == 0) ? int'(a_k) : int'(b_k);
        dr  = (i == 0) ? int'(a_row) : int'(b_row);
        dc  = (i == 0) ? int'(a_col) : int'(b_col);
        di  = (i == 0) ? int'(a_idx) : int'(b_idx);
        dmb = (i == 0) ? a_mbusy : b_mbusy;
        dbz = (i == 0) ? a_busy : b_busy;
        ddn = (i == 0) ? a_done : b_done;
        der = (i == 0) ? a_err : b_err;
        st  = (i == 0) ? start_a : start_b;
        md  = (i == 0) ? md_a : md_b;
        if (!rstn) model_reset(i);
        chk($sformatf("inst%0d disp_valid cyc%0d", i, cyc), int'(dv), int'(e_vld[i]));
        chk($sformatf("inst%0d mult_busy cyc%0d", i, cyc), int'(dmb), int'(m_bz[i]));
        chk($sformatf("inst%0d busy cyc%0d", i, cyc), int'(dbz), int'(m_phase[i] == 1 || m_phase[i] == 2));
        chk($sformatf("inst%0d done cyc%0d", i, cyc), int'(ddn), int'(m_phase[i] == 3));
        chk($sformatf("inst%0d err cyc%0d", i, cyc), int'(der), int'(m_err[i]));
        if (e_vld[i]) begin
          chk($sformatf("inst%0d disp_mult cyc%0d", i, cyc), dm, e_mult[i]);
          chk($sformatf("inst%0d disp_k cyc%0d", i, cyc), dk, e_k[i]);
          chk($sformatf("inst%0d disp_row cyc%0d", i, cyc), dr, e_row[i]);
          chk($sformatf("inst%0d disp_col cyc%0d", i, cyc), dc, e_col[i]);
          chk($sformatf("inst%0d disp_idx cyc%0d", i, cyc), di, e_idx[i]);
        end
        if (dv && i == 0) begin
          qa_mult.push_back(dm); qa_row.push_back(dr); qa_col.push_back(dc);
          qa_k.push_back(dk); qa_idx.push_back(di); qa_cyc.push_back(cyc);
        end
        if (dv && i == 1) begin
          qb_k.push_back(dk); qb_row.push_back(dr); qb_col.push_back(dc);
        end
        if (ddn) begin dn_cnt[i]++; done_cyc[i] = cyc; end
        if ((md & dmb) != 0) last_cmp[i] = cyc;
        if (st && rstn) start_cyc[i] = cyc;
        if (rstn) model_step(i, st, md);
      end
    end
  end

  task automatic wait_done(input int i, input int budget, input string nm);
    int n;
    logic seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge clk);
      seen = (i == 0) ? a_done : b_done;
      n++;
    end
    chk({nm, " reached done"}, int'(seen), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_disp_a(input int cnt, input int budget, input string nm);
    int n;
    n = 0;
    while (qa_mult.size() < cnt && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " dispatch count"}, qa_mult.size(), cnt);
  endtask

  task automatic pulse_start(input int i);
    @(posedge clk);
    #1;
    if (i == 0) start_a = 1'b1; else start_b = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  int exp_mult[9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
  int exp_row[9]  = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
  int exp_col[9]  = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
  int rel_cyc;
  int k_order_ok;

  initial begin
    clear_rec();
    // Reset held: start must not move anything.
    repeat (2) @(posedge clk);
    #1 start_a = 1'b1; start_b = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0; start_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset a_valid", int'(a_valid), 0);
    chk("reset a_busy", int'(a_busy), 0);
    chk("reset a_mbusy", int'(a_mbusy), 0);
    chk("reset b_busy", int'(b_busy), 0);
    rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle a_busy", int'(a_busy), 0);
    chk("idle a_done", int'(a_done), 0);

    // Sequencing, unit stride.
    clear_rec();
    auto_a = 1'b1;
    pulse_start(0);
    wait_done(0, 100, "seq");
    chk("seq dispatches", qa_mult.size(), 9);
    for (int j = 0; j < 9 && j < qa_mult.size(); j++) begin
      chk($sformatf("seq mult[%0d]", j), qa_mult[j], exp_mult[j]);
      chk($sformatf("seq row[%0d]", j), qa_row[j], exp_row[j]);
      chk($sformatf("seq col[%0d]", j), qa_col[j], exp_col[j]);
    end
    if (qa_cyc.size() > 0) chk("seq first dispatch latency", qa_cyc[0] - start_cyc[0], 2);
    chk("seq done pulses", dn_cnt[0], 1);
    chk("seq done after last completion", done_cyc[0], last_cmp[0] + 1);

    // Stride 2, two channels, with a spurious completion on an idle multiplier.
    clear_rec();
    auto_b = 1'b1;
    @(posedge clk);
    #1 start_b = 1'b1;
    @(posedge clk);
    #1 start_b = 1'b0; man_b = 4'b1000;
    @(posedge clk);
    #1 man_b = 4'b0000;
    wait_done(1, 200, "stride");
    chk("stride dispatches", qb_k.size(), 18);
    if (qb_k.size() == 18) begin
      chk("stride w0 k", qb_k[0], 0);   chk("stride w0 row", qb_row[0], 0);   chk("stride w0 col", qb_col[0], 0);
      chk("stride w2 col", qb_col[2], 4);
      chk("stride w3 row", qb_row[3], 2); chk("stride w3 col", qb_col[3], 0);
      chk("stride w8 k", qb_k[8], 0);   chk("stride w8 row", qb_row[8], 4);   chk("stride w8 col", qb_col[8], 4);
      chk("stride w9 k", qb_k[9], 1);   chk("stride w9 row", qb_row[9], 0);
      chk("stride w17 k", qb_k[17], 1); chk("stride w17 row", qb_row[17], 4); chk("stride w17 col", qb_col[17], 4);
      k_order_ok = 1;
      for (int j = 1; j < 18; j++) if (qb_k[j] < qb_k[j-1]) k_order_ok = 0;
      chk("stride channel order", k_order_ok, 1);
    end
    chk("spurious err sticky", int'(b_err), 1);
    chk("spurious done pulses", dn_cnt[1], 1);
    chk("spurious done timing", done_cyc[1], last_cmp[1] + 1);
    pulse_start(1);
    @(negedge clk);
    chk("start clears err", int'(b_err), 0);
    wait_done(1, 200, "stride rerun");

    // Pool exhaustion.
    clear_rec();
    auto_a = 1'b0;
    pulse_start(0);
    repeat (10) @(posedge clk);
    #1;
    chk("exhaust dispatches", qa_mult.size(), 4);
    chk("exhaust mult_busy", int'(a_mbusy), 15);
    chk("exhaust disp_valid", int'(a_valid), 0);
    rel_cyc = cyc;
    man_a = 4'b0100;
    @(posedge clk);
    #1 man_a = 4'b0000;
    wait_disp_a(5, 10, "exhaust release");
    if (qa_mult.size() >= 5) begin
      chk("release mult", qa_mult[4], 2);
      chk("release cycle", qa_cyc[4], rel_cyc + 2);
    end
    @(posedge clk);
    #1 man_a = 4'b1011; auto_a = 1'b1;
    @(posedge clk);
    #1 man_a = 4'b0000;
    wait_done(0, 100, "exhaust");
    chk("exhaust done pulses", dn_cnt[0], 1);
    chk("exhaust total dispatches", qa_mult.size(), 9);

    // Reset mid-pass.
    clear_rec();
    pulse_start(0);
    wait_disp_a(5, 20, "midreset");
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("midreset disp_valid", int'(a_valid), 0);
    chk("midreset mult_busy", int'(a_mbusy), 0);
    chk("midreset busy", int'(a_busy), 0);
    chk("midreset disp_idx", int'(a_idx), 0);
    chk("midreset disp_mult", int'(a_mult), 0);
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    clear_rec();
    pulse_start(0);
    wait_disp_a(1, 10, "restart");
    if (qa_mult.size() >= 1) begin
      chk("restart idx", qa_idx[0], 0);
      chk("restart k", qa_k[0], 0);
      chk("restart row", qa_row[0], 0);
      chk("restart col", qa_col[0], 0);
      chk("restart mult", qa_mult[0], 0);
    end
    wait_done(0, 100, "restart");

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/conv_window_scheduler.md
# conv_window_scheduler

Sequencing controller for the convolution multiplier pool. After `start`, it walks every output window of one convolution pass: channel, row and column. Each window is dispatched to a free multiplier, picked round-robin. The block tracks busy/done per multiplier and pulses `done` once every dispatched window has completed. It sits between the layer control FSM and the multiplier array and replaces ad-hoc free-multiplier searches with a registered, one-dispatch-per-cycle scheduler.

## Interface
- `N`, 32: input feature-map side length.
- `F`, 3: filter side length.
- `K`, 3: channel count.
- `S`, 1: stride, ≥1.
- `NMULT`, 64: multipliers in the pool.
- `MIDX`, 6: multiplier index width, ≥ clog2(NMULT).
- `CW`, 24: window counter width; must hold OUT·OUT·K, where OUT = (N−F)/S+1 (integer division).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin a pass; sampled only in IDLE.
- `mult_done`  in  NMULT  per-multiplier one-cycle completion pulse.
- `disp_valid`  out  1  one-cycle dispatch strobe.
- `disp_mult`  out  MIDX  target multiplier index.
- `disp_k`  out  CW  channel of the window.
- `disp_row`  out  CW  top-left row, a multiple of S.
- `disp_col`  out  CW  top-left column, a multiple of S.
- `disp_idx`  out  CW  sequential window number, 0..TOTAL−1.
- `mult_busy`  out  NMULT  registered busy bitmap.
- `busy`  out  1  high in RUN or DRAIN.
- `done`  out  1  one-cycle pulse when the pass completes.
- `err`  out  1  sticky protocol error; cleared only by reset or by a `start` accepted in IDLE.

## Operation
- TOTAL = OUT·OUT·K.
- States: IDLE, RUN, DRAIN, FIN.
  - IDLE→RUN when `start`=1. Entry clears the counters, `mult_busy`, the RR pointer and `err`.
  - RUN→DRAIN on the edge where the issued count reaches TOTAL.
  - DRAIN→FIN when the completed count equals TOTAL.
  - FIN→IDLE unconditionally after one cycle.
  - `start` outside IDLE is ignored.
- Grant rule in RUN, one per cycle at most:
  - Candidates are the multipliers whose registered `mult_busy` bit is 0.
  - Search begins at index `rr_ptr`, ascending, wrapping at NMULT−1→0. The first candidate wins.
  - On a grant, `rr_ptr` ← winner+1 (mod NMULT), the winner's busy bit is set, and the window counters advance.
- Window order: column fastest, then row, then channel.
  - `col` += S; when col+S > N−F, `col` ← 0 and `row` += S.
  - When the row wraps the same way, `row` ← 0 and `k` += 1.
  - `disp_idx` increments by 1 on each grant.
- Completion handling:
  - A set `mult_done[i]` with busy[i]=1 clears busy[i] and counts as one completion.
  - Multiple bits set in one cycle count by popcount.
  - A `mult_done[i]` with busy[i]=0 is ignored, not counted, and sets `err`.
- Simultaneous events:
  - A multiplier freed by `mult_done` in cycle t is not a candidate until t+1, because the grant uses the registered bitmap.
  - A grant and a done on different indices in the same cycle both take effect.
- Pool full (all busy): no dispatch; RUN holds until some bit frees.
- Reset mid-pass drops all state immediately. Multipliers are not notified; the layer FSM owns recovery.

## Timing
- Reset values: `disp_valid`=0, `disp_*`=0, `mult_busy`=0, `busy`=0, `done`=0, `err`=0, state IDLE, `rr_ptr`=0.
- All outputs are registered.
  - `start` sampled at edge e0 → RUN.
  - Grant decided in the cycle after e0 and registered at e1.
  - `disp_valid` is high in the cycle after e1, so latency is 2 edges from `start` to the first dispatch.
- Throughput is 1 dispatch per cycle while any multiplier is free. `disp_*` values are valid only while `disp_valid`=1 and are held otherwise.
- `mult_busy` reflects a grant in the same cycle as its `disp_valid`.
- `done` is high for exactly 1 cycle, in FIN. `busy` is low in that cycle.
- Minimum pass length is TOTAL+3 cycles when completions are instantaneous.

## Test plan
- Reset, then idle: all outputs 0. Pulse `start` with `rstn`=0 → no state change.
- Sequencing: N=5, F=3, K=1, S=1, NMULT=4, each multiplier done 1 cycle after its dispatch.
  - Required: 9 dispatches; `disp_row`/`disp_col` follow (0,0),(0,1),(0,2),(1,0)…(2,2).
  - `disp_mult` follows 0,1,2,3,0,…
  - `done` pulses exactly once, 1 cycle after the 9th completion.
- Stride and channels: N=6, F=2, K=2, S=2.
  - Required: OUT=3, TOTAL=18; k=0 windows finish before any k=1 window.
  - Cols and rows run 0,2,4.
- Pool exhaustion: NMULT=4, completions withheld.
  - Required: exactly 4 dispatches, then `disp_valid` stays 0 and `mult_busy`=4'b1111.
  - Release `mult_done`=4'b0100 → the next dispatch goes to multiplier 2, one cycle later.
- Spurious done: pulse `mult_done[3]` while busy[3]=0.
  - Required: `err`=1 sticky; completed count unchanged; `done` timing unaffected.
- Reset mid-pass: drop `rstn` after 5 dispatches.
  - Required: outputs return to reset values asynchronously.
  - A new `start` restarts at `disp_idx`=0, (k,row,col)=(0,0,0), `disp_mult`=0.
